// File: rtl/psqwg_pkg.sv
// Shared definitions for the multi-channel square-wave generator:
// channel state encoding and the counter-width helper.
package psqwg_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2,
      ST_RSVD = 2'd3
   } state_t;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/psqwg_channel.sv
// One square-wave channel: IDLE/HIGH/LOW FSM with prescaler, unit counter,
// shadowed m/n reloaded at period boundaries and a one-shot re-arm flag.
module psqwg_channel
   import psqwg_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int PRESCALE = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             oneshot,
   input  logic [CNT_W-1:0] m,
   input  logic [CNT_W-1:0] n,
   output logic             sq_wave,
   output logic             period_done,
   output logic             busy,
   output logic [ST_W-1:0]  state_dbg
);

   // A width of at least one bit keeps PRESCALE=1 legal.
   localparam int            PW     = (clog2(PRESCALE) > 0) ? clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   state_t           state;
   state_t           next_state;
   logic [PW-1:0]    pcnt;
   logic [CNT_W-1:0] ucnt;
   logic [CNT_W-1:0] m_sh;
   logic [CNT_W-1:0] n_sh;
   logic [CNT_W-1:0] target;
   logic             arm;
   logic             load;
   logic             boundary;
   logic             arm_clr;
   logic             phase_end;

   function automatic state_t dispatch(input logic [CNT_W-1:0] mv,
                                       input logic [CNT_W-1:0] nv);
      if (mv != '0) return ST_HIGH;
      if (nv != '0) return ST_LOW;
      return ST_IDLE;
   endfunction

   assign state_dbg = state;

   always_comb begin
      next_state = state;
      load       = 1'b0;
      boundary   = 1'b0;
      arm_clr    = 1'b0;
      target     = (state == ST_HIGH) ? m_sh : n_sh;
      phase_end  = (pcnt == P_LAST) && (ucnt == target - CNT_W'(1));

      // en low wins over a phase end, so an aborted period never strobes.
      case (state)
         ST_IDLE: begin
            if (en && arm) begin
               load       = 1'b1;
               next_state = dispatch(m, n);
            end
         end
         ST_HIGH: begin
            if (!en) next_state = ST_IDLE;
            else if (phase_end) begin
               if (n_sh != '0) next_state = ST_LOW;
               else            boundary   = 1'b1;
            end
         end
         ST_LOW: begin
            if (!en)            next_state = ST_IDLE;
            else if (phase_end) boundary   = 1'b1;
         end
         default: next_state = ST_IDLE;
      endcase

      if (boundary) begin
         if (oneshot) begin
            next_state = ST_IDLE;
            arm_clr    = 1'b1;
         end else begin
            load       = 1'b1;
            next_state = dispatch(m, n);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pcnt        <= '0;
         ucnt        <= '0;
         m_sh        <= '0;
         n_sh        <= '0;
         arm         <= 1'b1;
         sq_wave     <= 1'b0;
         period_done <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state <= next_state;

         if (load) begin
            m_sh <= m;
            n_sh <= n;
         end

         if (!en)          arm <= 1'b1;
         else if (arm_clr) arm <= 1'b0;

         // A reload into the same state is still a fresh entry.
         if ((next_state != state) || load) begin
            pcnt <= '0;
            ucnt <= '0;
         end else if ((state == ST_HIGH) || (state == ST_LOW)) begin
            if (pcnt == P_LAST) begin
               pcnt <= '0;
               ucnt <= ucnt + CNT_W'(1);
            end else begin
               pcnt <= pcnt + PW'(1);
            end
         end

         sq_wave     <= (next_state == ST_HIGH);
         busy        <= (next_state == ST_HIGH) || (next_state == ST_LOW);
         period_done <= boundary;
      end
   end

endmodule

// File: rtl/psqwg_multi.sv
// Multi-channel programmable square-wave generator; each channel is an
// independent psqwg_channel fed from its slice of the packed buses.
module psqwg_multi
   import psqwg_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int CNT_W    = 4,
   parameter int PRESCALE = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic [NUM_CH-1:0]       oneshot,
   input  logic [NUM_CH*CNT_W-1:0] m,
   input  logic [NUM_CH*CNT_W-1:0] n,
   output logic [NUM_CH-1:0]       sq_wave,
   output logic [NUM_CH-1:0]       period_done,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH*ST_W-1:0]  state_dbg
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      psqwg_channel #(
         .CNT_W    (CNT_W),
         .PRESCALE (PRESCALE)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .en          (en[i]),
         .oneshot     (oneshot[i]),
         .m           (m[i*CNT_W +: CNT_W]),
         .n           (n[i*CNT_W +: CNT_W]),
         .sq_wave     (sq_wave[i]),
         .period_done (period_done[i]),
         .busy        (busy[i]),
         .state_dbg   (state_dbg[i*ST_W +: ST_W])
      );
   end

endmodule

// File: tb/tb_psqwg_multi.sv
// Directed bench for psqwg_multi (2 channels, 4-bit fields, prescale 5):
// phase lengths, strobes, reload, degenerate values, one-shot, abort, reset.
module tb_psqwg_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] en;
   logic [1:0] oneshot;
   logic [3:0] m0, m1, n0, n1;
   logic [7:0] m, n;
   logic [1:0] sq_wave;
   logic [1:0] period_done;
   logic [1:0] busy;
   logic [3:0] state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int q0[$];
   int q1[$];

   assign m = {m1, m0};
   assign n = {n1, n0};

   psqwg_multi #(.NUM_CH(2), .CNT_W(4), .PRESCALE(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .oneshot     (oneshot),
      .m           (m),
      .n           (n),
      .sq_wave     (sq_wave),
      .period_done (period_done),
      .busy        (busy),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe timestamps, used for the phase/period checks.
   always @(posedge clk) begin
      #1;
      if (period_done[0] === 1'b1) q0.push_back(cyc);
      if (period_done[1] === 1'b1) q1.push_back(cyc);
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Number of clocks sq_wave[ch] stays at val, counting the current one.
   task automatic run_len(input int ch, input logic val, output int len);
      len = 0;
      while (sq_wave[ch] === val && len < 400) begin
         len++;
         step(1);
      end
   endtask

   // Clocks until the next period_done[ch].
   task automatic wait_done(input int ch, output int len);
      len = 0;
      do begin
         step(1);
         len++;
      end while (period_done[ch] !== 1'b1 && len < 400);
   endtask

   initial begin
      int len;
      int s0, s1, bad, strobes;

      rst = 1'b1; en = 2'b00; oneshot = 2'b00;
      m0 = 4'd0; m1 = 4'd0; n0 = 4'd0; n1 = 4'd0;
      step(2);
      chk("reset_sq",    32'(sq_wave), 32'd0);
      chk("reset_busy",  32'(busy), 32'd0);
      chk("reset_done",  32'(period_done), 32'd0);
      chk("reset_state", 32'(state_dbg), 32'd0);

      // Continuous m=3, n=2 on ch0
      rst = 1'b0; m0 = 4'd3; n0 = 4'd2; en = 2'b01;
      step(1);
      chk("cont_first_sq", 32'(sq_wave[0]), 32'd1);
      chk("cont_first_busy", 32'(busy[0]), 32'd1);
      run_len(0, 1'b1, len); chk("cont_high_len", 32'(len), 32'd15);
      chk("cont_busy_low", 32'(busy[0]), 32'd1);
      run_len(0, 1'b0, len); chk("cont_low_len", 32'(len), 32'd10);
      chk("cont_strobe", 32'(period_done[0]), 32'd1);
      chk("ch1_idle_sq", 32'(sq_wave[1]), 32'd0);
      chk("ch1_idle_busy", 32'(busy[1]), 32'd0);
      chk("ch1_idle_done", 32'(period_done[1]), 32'd0);

      // Reload: m0 changes during a HIGH that already loaded m=3
      m0 = 4'd1;
      run_len(0, 1'b1, len); chk("reload_cur_high", 32'(len), 32'd15);
      run_len(0, 1'b0, len); chk("reload_cur_low", 32'(len), 32'd10);
      run_len(0, 1'b1, len); chk("reload_next_high", 32'(len), 32'd5);
      run_len(0, 1'b0, len); chk("reload_next_low", 32'(len), 32'd10);

      // Degenerate m=0, n=4
      en = 2'b00; step(1);
      m0 = 4'd0; n0 = 4'd4; en = 2'b01; step(1);
      chk("m0_busy", 32'(busy[0]), 32'd1);
      chk("m0_sq", 32'(sq_wave[0]), 32'd0);
      wait_done(0, len); chk("m0_strobe1", 32'(len), 32'd20);
      wait_done(0, len); chk("m0_strobe2", 32'(len), 32'd20);
      chk("m0_sq_end", 32'(sq_wave[0]), 32'd0);

      // Degenerate m=4, n=0
      en = 2'b00; step(1);
      m0 = 4'd4; n0 = 4'd0; en = 2'b01; step(1);
      chk("n0_sq", 32'(sq_wave[0]), 32'd1);
      wait_done(0, len); chk("n0_strobe1", 32'(len), 32'd20);
      chk("n0_sq_mid", 32'(sq_wave[0]), 32'd1);
      wait_done(0, len); chk("n0_strobe2", 32'(len), 32'd20);
      chk("n0_sq_end", 32'(sq_wave[0]), 32'd1);

      // Degenerate m=n=0
      en = 2'b00; step(1);
      m0 = 4'd0; n0 = 4'd0; en = 2'b01; step(3);
      chk("mn0_busy", 32'(busy[0]), 32'd0);
      chk("mn0_sq", 32'(sq_wave[0]), 32'd0);
      chk("mn0_state", 32'(state_dbg[1:0]), 32'd0);

      // One-shot m=2, n=2 with en held high
      en = 2'b00; oneshot = 2'b01; m0 = 4'd2; n0 = 4'd2; step(1);
      en = 2'b01; step(1);
      chk("os_start_sq", 32'(sq_wave[0]), 32'd1);
      run_len(0, 1'b1, len); chk("os_high_len", 32'(len), 32'd10);
      wait_done(0, len); chk("os_low_len", 32'(len), 32'd10);
      chk("os_end_busy", 32'(busy[0]), 32'd0);
      chk("os_end_sq", 32'(sq_wave[0]), 32'd0);
      strobes = 0;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if (period_done[0] === 1'b1 || busy[0] === 1'b1) strobes++;
      end
      chk("os_stays_idle", 32'(strobes), 32'd0);
      en = 2'b00; step(1);
      en = 2'b01; step(1);
      chk("os_rearm_sq", 32'(sq_wave[0]), 32'd1);
      chk("os_rearm_busy", 32'(busy[0]), 32'd1);

      // Abort by en drop mid-HIGH
      step(3);
      en = 2'b00; step(1);
      chk("abort_sq", 32'(sq_wave[0]), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_done", 32'(period_done[0]), 32'd0);
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (period_done[0] === 1'b1) strobes++;
      end
      chk("abort_no_strobe", 32'(strobes), 32'd0);

      // Reset while ch0 is in LOW and ch1 is constant high
      oneshot = 2'b00; m0 = 4'd1; n0 = 4'd3; m1 = 4'd2; n1 = 4'd0; en = 2'b11;
      step(1);
      step(7);
      chk("prerst_low_sq", 32'(sq_wave[0]), 32'd0);
      chk("prerst_low_busy", 32'(busy[0]), 32'd1);
      chk("prerst_ch1_sq", 32'(sq_wave[1]), 32'd1);
      rst = 1'b1; en = 2'b00; step(1);
      chk("rst_mid_sq", 32'(sq_wave), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_done", 32'(period_done), 32'd0);
      chk("rst_mid_state", 32'(state_dbg), 32'd0);
      rst = 1'b0; step(2);

      // Independence: ch0 1/1, ch1 7/3, enabled 3 clocks apart
      m0 = 4'd1; n0 = 4'd1; m1 = 4'd7; n1 = 4'd3;
      q0.delete(); q1.delete();
      en = 2'b01; step(1); s0 = cyc;
      step(2);
      en = 2'b11; step(1); s1 = cyc;
      chk("ind_ch1_start_sq", 32'(sq_wave[1]), 32'd1);
      while (cyc < s1 + 105) step(1);
      chk("ind_ch0_count", 32'(q0.size()), 32'd10);
      if (q0.size() >= 1) chk("ind_ch0_first", 32'(q0[0] - s0), 32'd10);
      bad = 0;
      for (int i = 1; i < q0.size(); i++) if (q0[i] - q0[i-1] != 10) bad++;
      chk("ind_ch0_period", 32'(bad), 32'd0);
      chk("ind_ch1_count", 32'(q1.size()), 32'd2);
      if (q1.size() >= 2) begin
         chk("ind_ch1_first", 32'(q1[0] - s1), 32'd50);
         chk("ind_ch1_second", 32'(q1[1] - s1), 32'd100);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
